// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M multi-cycle multiply/divide unit (clk, rst_n, StartE, Funct3E, SrcAE, SrcBE, AbortE -> StallMD, DoneE, ResultE)
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StartE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        AbortE,
  output logic        StallMD,
  output logic        DoneE,
  output logic [31:0] ResultE
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [31:0] a_q, a_d, b_q, b_d, quo_q, quo_d, res_q, res_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic start, ovf_in, a_neg, b_neg, lt;
  logic [31:0] b_mag, quo_f, rem_f, mul_res;
  logic [33:0] sh;
  logic [32:0] diff;
  logic [63:0] ma, mb, prod;
  assign start = state_q == IDLE & StartE & ~AbortE;
  assign ovf_in = ~Funct3E[0] & (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);
  assign a_neg = ~f3_q[0] & a_q[31];
  assign b_neg = ~f3_q[0] & b_q[31];
  assign b_mag = b_neg ? -b_q : b_q;
  assign sh = {rem_q, quo_q[31]};
  assign lt = sh < {2'b0, b_mag};
  assign diff = sh[32:0] - {1'b0, b_mag};
  assign quo_f = {quo_q[30:0], ~lt};
  assign rem_f = lt ? sh[31:0] : diff[31:0];
  assign ma = {{32{a_q[31] & (f3_q[1] ^ f3_q[0])}}, a_q};
  assign mb = {{32{b_q[31] & ~f3_q[1] & f3_q[0]}}, b_q};
  assign prod = ma * mb;
  assign mul_res = f3_q == 3'b000 ? prod[31:0] : prod[63:32];
  assign StallMD = start | state_q == MUL | state_q == DIV;
  assign DoneE = done_q;
  assign ResultE = res_q;
  always_comb begin
    state_d = state_q;
    f3_d = f3_q;
    a_d = a_q;
    b_d = b_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (start) begin
        f3_d = Funct3E;
        a_d = SrcAE;
        b_d = SrcBE;
        rem_d = '0;
        quo_d = (~Funct3E[0] & SrcAE[31]) ? -SrcAE : SrcAE;
        cnt_d = 5'd31;
        if (!Funct3E[2]) state_d = MUL;
        else if (SrcBE == '0) begin
          state_d = DONE;
          res_d = Funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
        end else if (ovf_in) begin
          state_d = DONE;
          res_d = Funct3E[1] ? 32'h0 : 32'h8000_0000;
        end else state_d = DIV;
      end
      MUL: begin
        state_d = AbortE ? IDLE : DONE;
        res_d = AbortE ? res_q : mul_res;
      end
      DIV: if (AbortE) state_d = IDLE;
      else begin
        rem_d = {1'b0, rem_f};
        quo_d = quo_f;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d = f3_q[1] ? (a_neg ? -rem_f : rem_f) : ((a_neg ^ b_neg) ? -quo_f : quo_f);
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q <= f3_d;
      a_q <= a_d;
      b_q <= b_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      done_q <= done_d;
    end
endmodule
